// File: rtl/lbm_stream_engine.sv
// D2Q9 lattice sequencer: equilibrium fill, then fused collide-and-stream
// over two ping-pong banks split into nine per-direction memories.
//
// Ports:
//   clk_in, rst_n_in     clock, synchronous active-low reset
//   start_in             start pulse (accepted only when idle)
//   num_steps_in         steps to run, sampled on accepted start
//   busy_out, done_out   run in progress / one-cycle completion pulse
//   step_count_out       completed steps in this run
//   rd_bank_out          bank holding the current lattice
//   rd_en_out            read strobe, one cell per cycle
//   rd_addr_out          cell address, shared by all nine memories
//   rd_data_in           nine populations, valid RD_LAT cycles after rd_en_out
//   col_valid_out        cell populations to the collision module are valid
//   col_data_out         populations to collide
//   col_valid_in         collided result is valid (in order, one per cell)
//   col_data_in          collided populations
//   wr_bank_out          bank being written
//   wr_en_out            per-direction write enable
//   wr_addr_out          per-direction write address
//   wr_data_out          per-direction write data
module lbm_stream_engine #(
    parameter int GRID_W = 200,
    parameter int GRID_H = 158,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int EDGE_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_E = DATA_W'(8'h0F),
    parameter logic [DATA_W-1:0] INIT_O = DATA_W'(8'h01),
    parameter int CELLS = GRID_W * GRID_H,
    parameter int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [15:0]           num_steps_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [15:0]           step_count_out,
    output logic                  rd_bank_out,
    output logic                  rd_en_out,
    output logic [ADDR_W-1:0]     rd_addr_out,
    input  logic [9*DATA_W-1:0]   rd_data_in,
    output logic                  col_valid_out,
    output logic [9*DATA_W-1:0]   col_data_out,
    input  logic                  col_valid_in,
    input  logic [9*DATA_W-1:0]   col_data_in,
    output logic                  wr_bank_out,
    output logic [8:0]            wr_en_out,
    output logic [9*ADDR_W-1:0]   wr_addr_out,
    output logic [9*DATA_W-1:0]   wr_data_out
);

    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int FD = 32;
    localparam int CW = ADDR_W + 1;
    // Direction 0 sits in the low bits; only east (3) differs.
    localparam logic [9*DATA_W-1:0] INIT_VEC =
        {{5{INIT_O}}, INIT_E, {3{INIT_O}}};

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_SWAP, S_DONE
    } state_t;

    state_t state, next;

    logic [ADDR_W-1:0]   cnt;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [CW-1:0]       wr_cnt;
    logic [15:0]         num_q;
    logic [15:0]         step_q;
    logic                rd_bank;
    logic [RD_LAT-1:0]   vpipe;
    logic                col_valid_q;
    logic [9*DATA_W-1:0] col_data_q;
    logic [4:0]          wp;
    logic [4:0]          rp;
    logic [XW-1:0]       fx_m [FD];
    logic [YW-1:0]       fy_m [FD];
    logic [ADDR_W-1:0]   fa_m [FD];
    logic [8:0]          wr_en_q;
    logic                wr_bank_q;
    logic [9*ADDR_W-1:0] wr_addr_q;
    logic [9*DATA_W-1:0] wr_data_q;
    logic [9*ADDR_W-1:0] wa_n;
    logic [9*DATA_W-1:0] wd_n;
    logic                last_cell;
    logic                last_x;
    logic                take;
    logic                rd_en;

    function automatic int dx_of(input int d);
        case (d)
            2, 3, 4: return 1;
            6, 7, 8: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dy_of(input int d);
        case (d)
            1, 2, 8: return -1;
            4, 5, 6: return 1;
            default: return 0;
        endcase
    endfunction

    assign last_cell = (cnt == ADDR_W'(CELLS - 1));
    assign last_x    = (x == XW'(GRID_W - 1));
    assign rd_en     = (state == S_RUN);
    // Results are only meaningful while a step is in flight.
    assign take      = col_valid_in &&
                       (state == S_RUN || state == S_DRAIN);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  if (start_in) next = S_SETUP;
            S_SETUP: if (last_cell)
                         next = (num_q == 16'd0) ? S_DONE : S_RUN;
            S_RUN:   if (last_cell) next = S_DRAIN;
            S_DRAIN: if (wr_cnt == CW'(CELLS)) next = S_SWAP;
            S_SWAP:  next = (step_q + 16'd1 == num_q) ? S_DONE : S_RUN;
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // Stream targets for the cell at the head of the coordinate FIFO.
    // Wrapping is done by adding/subtracting a row or the whole lattice,
    // so no division or modulo is needed.
    always_comb begin
        wa_n = '0;
        wd_n = '0;
        for (int d = 0; d < 9; d++) begin
            int  nx;
            int  ny;
            int  t;
            logic oob;
            nx  = int'(fx_m[rp]) + dx_of(d);
            ny  = int'(fy_m[rp]) + dy_of(d);
            t   = int'(fa_m[rp]) + dx_of(d) + dy_of(d) * GRID_W;
            oob = 1'b0;
            if (nx < 0) begin
                t   = t + GRID_W;
                oob = 1'b1;
            end else if (nx >= GRID_W) begin
                t   = t - GRID_W;
                oob = 1'b1;
            end
            if (ny < 0) begin
                t   = t + CELLS;
                oob = 1'b1;
            end else if (ny >= GRID_H) begin
                t   = t - CELLS;
                oob = 1'b1;
            end
            wa_n[d*ADDR_W +: ADDR_W] = ADDR_W'(t);
            if (oob && EDGE_MODE == 1) begin
                wd_n[d*DATA_W +: DATA_W] = INIT_VEC[d*DATA_W +: DATA_W];
            end else begin
                wd_n[d*DATA_W +: DATA_W] = col_data_in[d*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rd_en) begin
            fx_m[wp] <= x;
            fy_m[wp] <= y;
            fa_m[wp] <= cnt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            wr_cnt      <= '0;
            num_q       <= '0;
            step_q      <= '0;
            rd_bank     <= 1'b0;
            vpipe       <= '0;
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
            wp          <= '0;
            rp          <= '0;
            wr_en_q     <= '0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_en_q  <= '0;
            vpipe[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            col_valid_q <= vpipe[RD_LAT-1];
            if (vpipe[RD_LAT-1]) begin
                col_data_q <= rd_data_in;
            end
            unique case (state)
                S_IDLE: begin
                    if (start_in) begin
                        num_q  <= num_steps_in;
                        step_q <= '0;
                        cnt    <= '0;
                        x      <= '0;
                        y      <= '0;
                        wr_cnt <= '0;
                        wp     <= '0;
                        rp     <= '0;
                    end
                end
                S_SETUP: begin
                    wr_en_q   <= 9'h1FF;
                    wr_bank_q <= 1'b0;
                    wr_addr_q <= {9{cnt}};
                    wr_data_q <= INIT_VEC;
                    if (last_cell) begin
                        cnt     <= '0;
                        rd_bank <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    wp <= wp + 1'b1;
                    if (last_cell) begin
                        cnt <= '0;
                        x   <= '0;
                        y   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (last_x) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                S_SWAP: begin
                    rd_bank <= ~rd_bank;
                    step_q  <= step_q + 16'd1;
                    wr_cnt  <= '0;
                end
                default: ;
            endcase
            if (take) begin
                rp        <= rp + 1'b1;
                wr_cnt    <= wr_cnt + 1'b1;
                wr_en_q   <= 9'h1FF;
                wr_bank_q <= ~rd_bank;
                wr_addr_q <= wa_n;
                wr_data_q <= wd_n;
            end
        end
    end

    assign busy_out       = state inside {S_SETUP, S_RUN, S_DRAIN, S_SWAP};
    assign done_out       = (state == S_DONE);
    assign step_count_out = step_q;
    assign rd_bank_out    = rd_bank;
    assign rd_en_out      = rd_en;
    assign rd_addr_out    = rd_en ? cnt : '0;
    assign col_valid_out  = col_valid_q;
    assign col_data_out   = col_data_q;
    assign wr_bank_out    = wr_bank_q;
    assign wr_en_out      = wr_en_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;

endmodule

// File: tb/tb_lbm_stream_engine.sv
// Bench for lbm_stream_engine: two instances (periodic and open edges)
// on a 4x3 lattice with modelled BRAM banks and a keyed collision unit.
module tb_lbm_stream_engine;

    localparam int W = 4;
    localparam int H = 3;
    localparam int CELLS = W * H;
    localparam int RL = 2;
    localparam int CL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] nsteps = '0;

    logic        busy [2];
    logic        done [2];
    logic [15:0] scnt [2];
    logic        rd_bank [2];
    logic        rd_en [2];
    logic [3:0]  rd_addr [2];
    logic [71:0] rd_data [2];
    logic        col_v [2];
    logic [71:0] col_d [2];
    logic        col_vi [2];
    logic [71:0] col_di [2];
    logic        wr_bank [2];
    logic [8:0]  wr_en [2];
    logic [35:0] wr_addr [2];
    logic [71:0] wr_data [2];

    logic [7:0]  mem [2][2][9][CELLS];
    logic [71:0] rdp [2][RL];
    logic        cv [2][CL];
    logic [71:0] cd [2][CL];
    int          seq [2];
    int          wcnt [2] = '{0, 0};
    int          dcnt [2] = '{0, 0};
    int          salt = 0;
    int          exp_m [9][CELLS];
    int          checks = 0;
    int          errors = 0;

    lbm_stream_engine #(.GRID_W(W), .GRID_H(H), .DATA_W(8),
                        .RD_LAT(RL), .EDGE_MODE(0)) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .num_steps_in(nsteps), .busy_out(busy[0]), .done_out(done[0]),
        .step_count_out(scnt[0]), .rd_bank_out(rd_bank[0]),
        .rd_en_out(rd_en[0]), .rd_addr_out(rd_addr[0]),
        .rd_data_in(rd_data[0]), .col_valid_out(col_v[0]),
        .col_data_out(col_d[0]), .col_valid_in(col_vi[0]),
        .col_data_in(col_di[0]), .wr_bank_out(wr_bank[0]),
        .wr_en_out(wr_en[0]), .wr_addr_out(wr_addr[0]),
        .wr_data_out(wr_data[0])
    );

    lbm_stream_engine #(.GRID_W(W), .GRID_H(H), .DATA_W(8),
                        .RD_LAT(RL), .EDGE_MODE(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .num_steps_in(nsteps), .busy_out(busy[1]), .done_out(done[1]),
        .step_count_out(scnt[1]), .rd_bank_out(rd_bank[1]),
        .rd_en_out(rd_en[1]), .rd_addr_out(rd_addr[1]),
        .rd_data_in(rd_data[1]), .col_valid_out(col_v[1]),
        .col_data_out(col_d[1]), .col_valid_in(col_vi[1]),
        .col_data_in(col_di[1]), .wr_bank_out(wr_bank[1]),
        .wr_en_out(wr_en[1]), .wr_addr_out(wr_addr[1]),
        .wr_data_out(wr_data[1])
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] key(int sl, int s, int c, int d);
        int k;
        k = sl + s * 29 + c * 7 + d * 13 + c * d * 3;
        return k[7:0];
    endfunction

    function automatic logic [71:0] keyvec(int sq);
        logic [71:0] v;
        for (int d = 0; d < 9; d++) begin
            v[d*8 +: 8] = key(salt, sq / CELLS, sq % CELLS, d);
        end
        return v;
    endfunction

    function automatic logic [71:0] rdword(int i, int b, int a);
        logic [71:0] v;
        v = '0;
        if (a < CELLS) begin
            for (int d = 0; d < 9; d++) v[d*8 +: 8] = mem[i][b][d][a];
        end
        return v;
    endfunction

    // BRAM banks, collision unit and event counters for both instances.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rdp[i][0] <= rdword(i, int'(rd_bank[i]), int'(rd_addr[i]));
            for (int k = 1; k < RL; k++) rdp[i][k] <= rdp[i][k-1];
            cv[i][0] <= col_v[i];
            cd[i][0] <= col_d[i] ^ keyvec(seq[i]);
            for (int k = 1; k < CL; k++) begin
                cv[i][k] <= cv[i][k-1];
                cd[i][k] <= cd[i][k-1];
            end
            if (!rst_n || (start && !busy[i])) seq[i] <= 0;
            else if (col_v[i]) seq[i] <= seq[i] + 1;
            if (!rst_n) begin
                for (int k = 0; k < CL; k++) cv[i][k] <= 1'b0;
            end
            for (int d = 0; d < 9; d++) begin
                if (wr_en[i][d] && int'(wr_addr[i][d*4 +: 4]) < CELLS)
                    mem[i][wr_bank[i]][d][wr_addr[i][d*4 +: 4]] <=
                        wr_data[i][d*8 +: 8];
            end
            wcnt[i] <= wcnt[i] + $countones(wr_en[i]);
            if (done[i]) dcnt[i] <= dcnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rd_data[i] = rdp[i][RL-1];
            col_vi[i]  = cv[i][CL-1];
            col_di[i]  = cd[i][CL-1];
        end
    end

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [255:0] outvec(int i);
        return 256'({busy[i], done[i], scnt[i], rd_bank[i], rd_en[i],
                     rd_addr[i], col_v[i], col_d[i], wr_bank[i],
                     wr_en[i], wr_addr[i], wr_data[i]});
    endfunction

    // Lattice after n steps: setup fill, then every population is keyed by
    // the collision unit and moved one cell along its direction.
    task automatic model(input int e, input int n);
        int cur [9][CELLS];
        int nxt [9][CELLS];
        int dxs [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
        int dys [9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
        for (int c = 0; c < CELLS; c++)
            for (int d = 0; d < 9; d++) cur[d][c] = (d == 3) ? 15 : 1;
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < CELLS; c++) begin
                for (int d = 0; d < 9; d++) begin
                    int tx, ty, v;
                    bit o;
                    v  = int'(8'(cur[d][c]) ^ key(salt, s, c, d));
                    tx = c % W + dxs[d];
                    ty = c / W + dys[d];
                    o  = (tx < 0 || tx >= W || ty < 0 || ty >= H);
                    nxt[d][((ty + H) % H) * W + (tx + W) % W] =
                        (o && e == 1) ? ((d == 3) ? 15 : 1) : v;
                end
            end
            cur = nxt;
        end
        exp_m = cur;
    endtask

    task automatic do_run(input int n, input bit poke, output int cyc);
        @(negedge clk);
        nsteps = 16'(n);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done[0] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 40);
        end
        start = 1'b0;
        chk("done_seen", 256'(done[0]), 256'(1));
        chk("done_seen_open", 256'(done[1]), 256'(1));
        chk("busy_at_done", 256'(busy[0]), 256'(0));
    endtask

    task automatic run_check(input int n, input bit poke);
        int cyc, d0, w0;
        salt = int'($urandom_range(0, 255));
        d0 = dcnt[0];
        w0 = wcnt[0];
        do_run(n, poke, cyc);
        repeat (2) @(negedge clk);
        if (n == 0)
            chk("setup_latency", 256'(cyc >= 12 && cyc <= 13), 256'(1));
        chk("done_once", 256'(dcnt[0] - d0), 256'(1));
        chk("write_total", 256'(wcnt[0] - w0), 256'(9 * CELLS * (n + 1)));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("steps%0d", i), 256'(scnt[i]), 256'(n));
            chk($sformatf("rd_bank%0d", i), 256'(rd_bank[i]), 256'(n % 2));
            model(i, n);
            for (int c = 0; c < CELLS; c++) begin
                logic [71:0] g, x;
                for (int d = 0; d < 9; d++) begin
                    g[d*8 +: 8] = mem[i][n % 2][d][c];
                    x[d*8 +: 8] = exp_m[d][c][7:0];
                end
                chk($sformatf("lat_e%0d_n%0d_c%0d", i, n, c),
                    256'(g), 256'(x));
            end
        end
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_out%0d", i), outvec(i), '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_check(0, 1'b0);

        run_check(1, 1'b0);
        chk("wrap_e", 256'(mem[0][1][3][4]), 256'(8'h0F ^ key(salt, 0, 7, 3)));
        chk("wrap_ne", 256'(mem[0][1][2][8]), 256'(8'h01 ^ key(salt, 0, 3, 2)));
        chk("open_e", 256'(mem[1][1][3][4]), 256'(8'h0F));
        chk("open_ne", 256'(mem[1][1][2][8]), 256'(8'h01));
        chk("inner_e", 256'(mem[0][1][3][6]), 256'(8'h0F ^ key(salt, 0, 5, 3)));
        chk("inner_e_open", 256'(mem[1][1][3][6]),
            256'(8'h0F ^ key(salt, 0, 5, 3)));

        run_check(3, 1'b1);

        for (int r = 0; r < 3; r++)
            run_check(int'($urandom_range(1, 4)), 1'b0);

        // Abandon a run partway through its second step.
        salt = int'($urandom_range(0, 255));
        @(negedge clk);
        nsteps = 16'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(scnt[0] == 16'd1 && rd_en[0]) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_step2", 256'(k < 2000), 256'(1));
        k = dcnt[0];
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("midrun_reset%0d", i), outvec(i), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", 256'(dcnt[0] - k), 256'(0));
        chk("idle_after_reset", 256'(busy[0]), 256'(0));

        run_check(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
